// File: rtl/uart_pkg.sv
// Shared UART receive definitions: FSM encoding, legal oversampling ratios,
// parity types and the per-frame configuration snapshot.
package uart_pkg;

  localparam int unsigned PRESCALE_W = 6;

  localparam logic [PRESCALE_W-1:0] PRESCALE_8  = 6'd8;
  localparam logic [PRESCALE_W-1:0] PRESCALE_16 = 6'd16;
  localparam logic [PRESCALE_W-1:0] PRESCALE_32 = 6'd32;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  typedef struct packed {
    logic [PRESCALE_W-1:0] prescale;
    logic                  par_en;
    logic                  par_typ;
  } rx_cfg_t;

  // Anything that is not 16 or 32 runs at 8x oversampling.
  function automatic logic [PRESCALE_W-1:0] norm_prescale(input logic [PRESCALE_W-1:0] p);
    logic [PRESCALE_W-1:0] r;
    r = PRESCALE_8;
    if (p == PRESCALE_16) r = PRESCALE_16;
    if (p == PRESCALE_32) r = PRESCALE_32;
    return r;
  endfunction

endpackage

// File: rtl/uart_rx_core_if.sv
// Serial line, frame configuration and received-frame result signals of the
// UART receiver; master drives the line, slave is the receiver.
interface uart_rx_core_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  RX_IN;
  logic [5:0]            Prescale;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  data_valid;
  logic                  par_err;
  logic                  stp_err;

  modport master (
    output RX_IN, Prescale, PAR_EN, PAR_TYP,
    input  P_DATA, data_valid, par_err, stp_err
  );

  modport slave (
    input  RX_IN, Prescale, PAR_EN, PAR_TYP,
    output P_DATA, data_valid, par_err, stp_err
  );
endinterface

// File: rtl/rx_data_sampler.sv
// Per-bit edge counter and three-point majority-vote sampler around mid-bit.
module rx_data_sampler
  import uart_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  input  logic                  rx_i,
  output logic                  bit_c,
  output logic                  wrap_c
);

  logic [PRESCALE_W-1:0] edge_cnt_q;
  logic [PRESCALE_W-1:0] half_c;
  logic [2:0]            smp_q;

  assign half_c = prescale_i >> 1;
  assign wrap_c = (edge_cnt_q == prescale_i - PRESCALE_W'(1));
  assign bit_c  = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_q[2]) | (smp_q[1] & smp_q[2]);

  // Counter holds at 0 while idle so the first bit starts aligned to the start edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      edge_cnt_q <= '0;
      smp_q      <= '0;
    end else if (!en_i) begin
      edge_cnt_q <= '0;
    end else begin
      edge_cnt_q <= wrap_c ? '0 : edge_cnt_q + PRESCALE_W'(1);
      if (edge_cnt_q == half_c - PRESCALE_W'(1)) smp_q[0] <= rx_i;
      if (edge_cnt_q == half_c)                  smp_q[1] <= rx_i;
      if (edge_cnt_q == half_c + PRESCALE_W'(1)) smp_q[2] <= rx_i;
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: frame FSM, LSB-first deserializer, parity/stop checking and
// one-cycle result pulses; bit timing comes from rx_data_sampler.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input logic           clk,
  input logic           rst,
  uart_rx_core_if.slave bus
);

  localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  rx_state_e             state_q;
  rx_cfg_t               cfg_q;
  logic [CNT_W-1:0]      bit_cnt_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [DATA_WIDTH-1:0] shift_d;
  logic [DATA_WIDTH-1:0] p_data_q;
  logic                  par_bad_q;
  logic                  data_valid_q;
  logic                  par_err_q;
  logic                  stp_err_q;
  logic                  par_exp_c;
  logic                  bit_c;
  logic                  wrap_c;

  rx_data_sampler u_sampler (
    .clk        (clk),
    .rst        (rst),
    .en_i       (state_q != IDLE),
    .prescale_i (cfg_q.prescale),
    .rx_i       (bus.RX_IN),
    .bit_c      (bit_c),
    .wrap_c     (wrap_c)
  );

  // New bits enter at the MSB so the first (LSB) bit ends up in bit 0.
  always_comb begin
    shift_d   = {bit_c, shift_q[DATA_WIDTH-1:1]};
    par_exp_c = ^shift_q;
    case (cfg_q.par_typ)
      PAR_EVEN: par_exp_c = ^shift_q;
      PAR_ODD:  par_exp_c = ~^shift_q;
      default:  par_exp_c = ^shift_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cfg_q        <= '{prescale: PRESCALE_8, par_en: 1'b0, par_typ: PAR_EVEN};
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      p_data_q     <= '0;
      par_bad_q    <= 1'b0;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
    end else begin
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          // Configuration is frozen here for the whole frame.
          if (!bus.RX_IN) begin
            state_q   <= START;
            cfg_q     <= '{prescale: norm_prescale(bus.Prescale),
                           par_en:   bus.PAR_EN,
                           par_typ:  bus.PAR_TYP};
            bit_cnt_q <= '0;
            par_bad_q <= 1'b0;
          end
        end
        START: begin
          if (wrap_c) state_q <= bit_c ? IDLE : DATA;
        end
        DATA: begin
          if (wrap_c) begin
            shift_q <= shift_d;
            if (bit_cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
              bit_cnt_q <= '0;
              state_q   <= cfg_q.par_en ? PARITY : STOP;
            end else begin
              bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end
          end
        end
        PARITY: begin
          if (wrap_c) begin
            par_bad_q <= (bit_c != par_exp_c);
            state_q   <= STOP;
          end
        end
        STOP: begin
          // Either a clean frame or its error flags; P_DATA only moves on a clean frame.
          if (wrap_c) begin
            state_q <= IDLE;
            if (par_bad_q || !bit_c) begin
              par_err_q <= par_bad_q;
              stp_err_q <= ~bit_c;
            end else begin
              data_valid_q <= 1'b1;
              p_data_q     <= shift_q;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.P_DATA     = p_data_q;
  assign bus.data_valid = data_valid_q;
  assign bus.par_err    = par_err_q;
  assign bus.stp_err    = stp_err_q;

endmodule

// File: doc/uart_rx_core.md
UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the number of data bits per frame.
REQ-002 The block SHALL have input clk, 1 bit: the oversampling clock, running at Prescale x baud rate.
REQ-003 The block SHALL have input rst, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have input RX_IN, 1 bit: the serial line, idle high, LSB first, already synchronised to clk.
REQ-005 The block SHALL have input Prescale, 6 bits: oversampling ratio; legal values 8, 16 and 32.
REQ-006 The block SHALL have input PAR_EN, 1 bit: when 1, a parity bit follows the data bits.
REQ-007 The block SHALL have input PAR_TYP, 1 bit: 0 = even parity, 1 = odd parity.
REQ-008 The block SHALL have output P_DATA, DATA_WIDTH bits: the received byte, held until the next valid frame.
REQ-009 The block SHALL have output data_valid, 1 bit: a one-cycle pulse when a frame is received without errors.
REQ-010 The block SHALL have output par_err, 1 bit: a one-cycle pulse when the frame has a parity mismatch.
REQ-011 The block SHALL have output stp_err, 1 bit: a one-cycle pulse when the stop bit is sampled as 0.

Function
REQ-012 The FSM SHALL have exactly these states: IDLE, START, DATA, PARITY, STOP.
REQ-013 In IDLE, the clock edge E0 that samples RX_IN=0 SHALL move the FSM to START with edge_cnt=0, and SHALL latch Prescale, PAR_EN and PAR_TYP for the whole frame.
REQ-014 A Prescale value other than 16 or 32 SHALL be treated as 8.
REQ-015 edge_cnt SHALL count 0..P-1 per bit and wrap to 0 on the edge after P-1; the FSM SHALL advance bit or state on that wrap edge.
REQ-016 The sampler SHALL capture RX_IN at edge_cnt = P/2-1, P/2 and P/2+1, and the bit value SHALL be the 2-of-3 majority vote.
REQ-017 START: if the voted start bit is 1 (glitch), the FSM SHALL return to IDLE at the end of the bit with no output pulse; otherwise it SHALL go to DATA.
REQ-018 DATA: DATA_WIDTH bits SHALL be shifted in LSB first (right shift, new bit entering the MSB), and a bit counter SHALL select PARITY (PAR_EN=1) or STOP (PAR_EN=0) after the last bit.
REQ-019 PARITY: the expected bit SHALL be the XOR of the data bits when PAR_TYP=0 and its inverse when PAR_TYP=1; a mismatch SHALL set an internal error flag.
REQ-020 STOP: the wrap edge SHALL return the FSM to IDLE, the next frame's start bit being detectable on the following edge.
REQ-021 On that STOP wrap edge the block SHALL register exactly one of: data_valid=1 with P_DATA updated, or par_err and/or stp_err set, each high for one cycle.
REQ-022 P_DATA SHALL NOT change when a frame has an error.
REQ-023 Latency: the pulse SHALL be visible in the cycle following edge E0 + N*P, with N = 1 + DATA_WIDTH + PAR_EN + 1.
REQ-024 Changes on Prescale, PAR_EN or PAR_TYP during a frame SHALL be ignored until the next IDLE.

Reset
REQ-025 When rst=0, the block SHALL immediately force: state IDLE, edge_cnt 0, bit counter 0, shift register 0, P_DATA 0x00, data_valid 0, par_err 0, stp_err 0.
REQ-026 A reset asserted mid-frame SHALL abort the frame with no pulse, and the next falling edge on RX_IN after rst=1 SHALL start a new frame.

Structure
REQ-027 The shared package uart_pkg SHALL hold the state encoding, the legal Prescale constants (8/16/32) and the parity type constants (EVEN=0, ODD=1).
REQ-028 The edge counter and the majority-vote logic SHALL be one sub-module, rx_data_sampler; the FSM, deserializer and checkers SHALL reside in uart_rx_core.

Verification
REQ-029 Test: P=8, PAR_EN=1, PAR_TYP=0, byte 0xA5 (parity 0, stop 1) -> data_valid high one cycle, 88 edges after E0, with P_DATA=0xA5 and no error pulses.
REQ-030 Test: P=16, PAR_EN=1, PAR_TYP=1, byte 0x3C sent with parity 0 -> par_err high one cycle, data_valid=0, P_DATA keeps its previous value.
REQ-031 Test: P=32, PAR_EN=0, byte 0xFF with stop bit 0 -> stp_err high one cycle, 320 edges after E0.
REQ-032 Test: P=8, RX_IN low for 2 cycles in IDLE -> no pulse, FSM back in IDLE after 8 edges; the next valid frame 0x5A is received correctly.
REQ-033 Test: P=16, single-cycle 1-glitch at edge_cnt=P/2 on data bit 0 of 0x00 -> the vote rejects the glitch and P_DATA=0x00 is received.
REQ-034 Test: rst pulsed low during DATA bit 3, then frame 0x81 sent -> no pulse for the aborted frame, then data_valid with P_DATA=0x81.
